// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter/sequencer sharing one full_adder among
// N_REQ requesters. A request is accepted in IDLE, the add runs in EXEC, and
// the registered sum/carry is presented in RESP until resp_ready.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   req_valid      per-requester pending flag
//   req_a, req_b   packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_ready      one-hot (or zero) accept strobe, IDLE only
//   resp_valid     result available (RESP)
//   resp_id        one-hot owner of the current result
//   resp_sum       registered WIDTH-bit sum
//   resp_cout      registered carry out of the MSB
//   resp_ready     consumer accepts the result
//   busy           high in EXEC and RESP

module full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    output logic [N_REQ-1:0]       resp_id,
    output logic [WIDTH-1:0]       resp_sum,
    output logic                   resp_cout,
    input  logic                   resp_ready,
    output logic                   busy
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   resp_sum_q, resp_sum_d;
    logic               resp_cout_q, resp_cout_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [N_REQ-1:0]   winner_oh;
    int unsigned        cand;
    int unsigned        base;

    full_adder #(.WIDTH(WIDTH)) u_add (
        .a    (op_a_q),
        .b    (op_b_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Scan ptr, ptr+1, ... (mod N_REQ); first pending requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
        winner_oh = N_REQ'(1) << winner;
        base      = 32'(winner) * WIDTH;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = winner_oh;
                    grant_d   = winner_oh;
                    gidx_d    = winner;
                    op_a_d    = req_a[base +: WIDTH];
                    op_b_d    = req_b[base +: WIDTH];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_sum_d  = add_sum;
                resp_cout_d = add_cout;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d   = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // No accept strobe may escape while reset is held.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_id    = resp_valid ? grant_q : '0;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (WIDTH=32, N_REQ=4). The reference
// model tracks the round-robin pointer as an integer and computes sums with
// 64-bit arithmetic.

module tb_adder_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [N-1:0]   resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;
    logic           resp_ready;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;
    int cyc = 0;

    adder_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int exp_winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return s[W:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
        tick(); tick();
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", resp_valid); end
        total++; if (resp_id !== 4'b0000) begin bad++; $display("FAIL rst_id: got %b want 0000", resp_id); end
        total++; if ({resp_cout, resp_sum} !== 33'h0) begin bad++; $display("FAIL rst_sum: got %0h want 0", {resp_cout, resp_sum}); end
        req_valid = '0; rst = 1'b0; resp_ready = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        set_ops(2, 32'h0000_0005, 32'h0000_0007);
        req_valid = 4'b0100; resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        tick();
        req_valid = '0;
        #1;
        total++; if ({busy, resp_valid, req_ready} !== 6'b100000) begin bad++; $display("FAIL single_exec: got busy/valid/ready %b want 100000", {busy, resp_valid, req_ready}); end
        tick();
        total++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_resp_valid: got %b%b want 11", resp_valid, busy); end
        total++; if ({resp_cout, resp_sum} !== 33'h0_0000_000C) begin bad++; $display("FAIL single_sum: got %0h want c", {resp_cout, resp_sum}); end
        total++; if (resp_id !== 4'b0100) begin bad++; $display("FAIL single_id: got %b want 0100", resp_id); end
        tick();
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_back_idle: got %b%b want 00", resp_valid, busy); end
        total++; if (resp_sum !== 32'h0000_000C) begin bad++; $display("FAIL single_sum_hold: got %0h want c", resp_sum); end
        model_ptr = 3;
    endtask

    task automatic test_carry();
        logic [W-1:0] va [2];
        logic [W-1:0] vb [2];
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
        va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            set_ops(0, va[i], vb[i]);
            req_valid = 4'b0001; resp_ready = 1'b1;
            #1;
            total++; if (req_ready !== onehot(exp_winner(req_valid, model_ptr))) begin bad++; $display("FAIL carry_ready%0d: got %b want 0001", i, req_ready); end
            tick();
            req_valid = '0;
            tick();
            total++; if ({resp_cout, resp_sum} !== 33'h1_0000_0000) begin bad++; $display("FAIL carry_sum%0d: got %0h want 100000000", i, {resp_cout, resp_sum}); end
            tick();
            model_ptr = 1;
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        int last_cyc;
        int w;
        logic [W:0] e;
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1; tick(); rst = 1'b0; model_ptr = 0;
        for (int k = 0; k < N; k++) set_ops(k, $urandom, $urandom);
        req_valid = '1; resp_ready = 1'b1;
        last_cyc = 0;
        for (int op = 0; op < 5; op++) begin
            #1;
            w = exp_winner(req_valid, model_ptr);
            total++; if (req_ready !== onehot(order[op]) || w != order[op]) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", op, req_ready, onehot(order[op])); end
            if (op > 0) begin
                total++; if (cyc - last_cyc != 3) begin bad++; $display("FAIL rr_interval%0d: got %0d want 3", op, cyc - last_cyc); end
            end
            last_cyc = cyc;
            e = ref_add(req_a[w*W +: W], req_b[w*W +: W]);
            tick(); tick();
            total++; if ({resp_cout, resp_sum} !== e || resp_id !== onehot(w)) begin bad++; $display("FAIL rr_result%0d: got %0h/%b want %0h/%b", op, {resp_cout, resp_sum}, resp_id, e, onehot(w)); end
            tick();
            model_ptr = (w + 1) % N;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W:0] e1, e3;
        set_ops(1, $urandom, $urandom);
        set_ops(3, $urandom, $urandom);
        e1 = ref_add(req_a[1*W +: W], req_b[1*W +: W]);
        e3 = ref_add(req_a[3*W +: W], req_b[3*W +: W]);
        req_valid = 4'b0010; resp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_ready: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        for (int h = 0; h < 5; h++) begin
            total++; if (resp_valid !== 1'b1 || {resp_cout, resp_sum} !== e1 || resp_id !== 4'b0010 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b s=%0h id=%b rdy=%b want v=1 s=%0h id=0010 rdy=0000", h, resp_valid, {resp_cout, resp_sum}, resp_id, req_ready, e1);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release: got busy=%b v=%b rdy=%b want 0 0 1000", busy, resp_valid, req_ready); end
        resp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        total++; if ({resp_cout, resp_sum} !== e3 || resp_id !== 4'b1000) begin bad++; $display("FAIL bp_next: got %0h/%b want %0h/1000", {resp_cout, resp_sum}, resp_id, e3); end
        tick();
        model_ptr = 0;
    endtask

    task automatic test_reset_mid();
        logic [W:0] e1;
        set_ops(2, 32'h1111_0000, 32'h0000_2222);
        set_ops(1, 32'hA5A5_0001, 32'h0101_0101);
        e1 = ref_add(32'hA5A5_0001, 32'h0101_0101);
        req_valid = 4'b0100; resp_ready = 1'b1;
        tick();
        rst = 1'b1; req_valid = 4'b1010;
        tick();
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_sum !== '0 || req_ready !== '0) begin
            bad++; $display("FAIL rstmid_clear: got v=%b busy=%b sum=%0h rdy=%b want 0 0 0 0000", resp_valid, busy, resp_sum, req_ready);
        end
        rst = 1'b0; model_ptr = 0;
        #1;
        total++; if (req_ready !== onehot(exp_winner(req_valid, model_ptr))) begin bad++; $display("FAIL rstmid_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        total++; if ({resp_cout, resp_sum} !== e1 || resp_id !== 4'b0010) begin bad++; $display("FAIL rstmid_result: got %0h/%b want %0h/0010", {resp_cout, resp_sum}, resp_id, e1); end
        tick();
        model_ptr = 2;
    endtask

    task automatic test_operand_sampling();
        logic [W:0] e;
        set_ops(0, 32'h0000_1234, 32'h0000_0010);
        e = ref_add(32'h0000_1234, 32'h0000_0010);
        req_valid = 4'b0001; resp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL samp_ready: got %b want 0001", req_ready); end
        tick();
        set_ops(0, 32'hFFFF_0000, 32'hFFFF_0000);
        req_valid = '0;
        tick();
        total++; if ({resp_cout, resp_sum} !== e) begin bad++; $display("FAIL samp_sum: got %0h want %0h", {resp_cout, resp_sum}, e); end
        tick();
        model_ptr = 1;
    endtask

    task automatic test_random();
        int w;
        int holds;
        logic [W:0] e;
        logic [N-1:0] m;
        for (int it = 0; it < 60; it++) begin
            m = N'($urandom_range(0, 15));
            req_valid = m;
            for (int k = 0; k < N; k++) set_ops(k, $urandom, (it % 4 == 0) ? ~req_a[k*W +: W] + 32'($urandom_range(0, 1)) : $urandom);
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            w = exp_winner(m, model_ptr);
            total++; if (req_ready !== onehot(w)) begin bad++; $display("FAIL rnd_ready%0d: got %b want %b", it, req_ready, onehot(w)); end
            if (w < 0) begin
                tick();
                continue;
            end
            e = ref_add(req_a[w*W +: W], req_b[w*W +: W]);
            tick();
            req_valid = N'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) set_ops(k, $urandom, $urandom);
            resp_ready = 1'($urandom_range(0, 1));
            tick();
            holds = $urandom_range(0, 3);
            resp_ready = 1'b0;
            for (int h = 0; h < holds; h++) begin
                #1;
                total++; if (resp_valid !== 1'b1 || {resp_cout, resp_sum} !== e || resp_id !== onehot(w) || req_ready !== '0) begin
                    bad++; $display("FAIL rnd_hold%0d: got v=%b s=%0h id=%b want v=1 s=%0h id=%b", it, resp_valid, {resp_cout, resp_sum}, resp_id, e, onehot(w));
                end
                tick();
            end
            resp_ready = 1'b1;
            #1;
            total++; if (resp_valid !== 1'b1 || {resp_cout, resp_sum} !== e || resp_id !== onehot(w)) begin
                bad++; $display("FAIL rnd_result%0d: got v=%b s=%0h id=%b want v=1 s=%0h id=%b", it, resp_valid, {resp_cout, resp_sum}, resp_id, e, onehot(w));
            end
            tick();
            resp_ready = 1'b0;
            model_ptr = (w + 1) % N;
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_operand_sampling();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares a single `full_adder` instance (WIDTH-bit unsigned add, carry-in 0) among N_REQ requesters in the ALU. It grants one request at a time through a valid/ready handshake, latches the operands, runs the add in a dedicated execute cycle, and holds the registered sum/carry on a shared response port until the response is accepted. Only this block instantiates the adder; ALU clients reach it solely through this block.

## Interface
- WIDTH, 32: operand and sum width, passed to `full_adder`
- N_REQ, 4: number of requesters, 2..8
- clk  input  1  rising-edge clock, sole clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  bit k: requester k has an operation pending
- req_a  input  N_REQ*WIDTH  requester k operand A at [k*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  requester k operand B, same packing
- req_ready  output  N_REQ  one-hot or zero; bit k high: requester k accepted this cycle
- resp_valid  output  1  result available
- resp_id  output  N_REQ  one-hot owner of the current result
- resp_sum  output  WIDTH  registered sum
- resp_cout  output  1  registered carry out of the MSB
- resp_ready  input  1  consumer accepts the result
- busy  output  1  high in EXEC and RESP

## Operation
- States: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE: winner = first k with req_valid[k] set, scanning ptr, ptr+1, … mod N_REQ. req_ready[winner] = 1 combinationally, all other bits 0. If no req_valid, req_ready = 0 and the block stays in IDLE. On a handshake, the block captures req_a/req_b slices into op_a/op_b and the winner into grant, then goes to EXEC.
- EXEC: the adder sees op_a/op_b; sum and cout are registered into resp_sum/resp_cout and the block goes to RESP. This state lasts exactly one cycle and cannot stall.
- RESP: resp_valid = 1 and resp_id = grant. resp_sum and resp_cout are stable. When resp_ready = 1, the block returns to IDLE and sets ptr = (grant index + 1) mod N_REQ. Otherwise it holds.
- req_ready = 0 in EXEC and RESP. New requests wait and are never dropped.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true carry. There is no carry-in.
- A requester may deassert req_valid before it is granted without side effects. Its operands are sampled only in the handshake cycle.
- resp_sum and resp_cout keep their last value after the response is accepted, until the next EXEC. resp_valid gates their meaning.

## Timing
- Handshake in cycle T, result registered at end of T+1, resp_valid high from cycle T+2.
- Minimum issue interval is 3 cycles: handshake, EXEC, RESP accepted in the same cycle it is presented. The next grant can occur in the cycle after acceptance.
- Reset values: state IDLE, ptr = 0, grant = 0, op_a = op_b = 0, resp_sum = 0, resp_cout = 0, resp_valid = 0, resp_id = 0, req_ready = 0, busy = 0.
- Reset asserted in any state takes effect at the next edge: the in-flight operation and pending response are discarded and ptr returns to 0. While rst is high, req_ready = 0.
- Simultaneous requests: exactly one grant per handshake, chosen by ptr order. Every continuously asserting requester is granted within N_REQ operations.
- resp_ready while not in RESP is ignored.

## Test plan
- Single op, N_REQ=4, WIDTH=32: requester 2 sends a=0x0000_0005, b=0x0000_0007 with resp_ready held high → req_ready=4'b0100 in T, resp_valid at T+2 with sum=0x0000_000C, cout=0, resp_id=4'b0100, busy high for T+1..T+2.
- Carry out: a=0xFFFF_FFFF, b=0x0000_0001 → sum=0x0000_0000, cout=1. Then a=0x8000_0000, b=0x8000_0000 → sum=0, cout=1.
- Round-robin: all four req_valid held high with resp_ready=1 → grants in order 0,1,2,3,0, one grant every 3 cycles, each result matching that requester's operands.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid, resp_sum and resp_id stable, req_ready=0 throughout. Then resp_ready=1 for 1 cycle → IDLE the next cycle and a new grant is possible.
- Reset mid-op: assert rst during EXEC → the next cycle has resp_valid=0, busy=0, resp_sum=0. After release with requests 1 and 3 pending → requester 1 is granted first (ptr=0).
- Operand sampling: change req_a of the granted requester in T+1 → the result reflects the T value only.
